// File: rtl/da_pkg.sv
// Shared constants and FSM encoding for the distributed-arithmetic FIR slice feeder.
package da_pkg;
    localparam int SW     = 16;
    localparam int NTAP   = 64;
    localparam int ACC_W  = 39;
    localparam int ADDR_W = 8;
    localparam int NBANK  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT,
        SETTLE
    } state_t;
endpackage

// File: rtl/da_delay_line.sv
// 64-tap sample delay line with a combinational bit-slice select into eight 8-bit DA addresses.
module da_delay_line
    import da_pkg::*;
#(
    parameter int SW            = da_pkg::SW,
    parameter int NTAP          = da_pkg::NTAP,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           shift,
    input  logic [SW-1:0]                  din,
    input  logic [$clog2(SW)-1:0]          bit_sel,
    output logic [NBANK-1:0][ADDR_W-1:0]   slice
);
    logic [NTAP-1:0][SW-1:0] taps;
    logic [SW-1:0]           msb_flip;
    logic [SW-1:0]           din_in;

    // Offset-binary entry: flipping the MSB turns two's complement into offset binary.
    assign msb_flip = (OFFSET_BINARY != 0) ? {1'b1, {(SW-1){1'b0}}} : '0;
    assign din_in   = din ^ msb_flip;

    always_ff @(posedge clk) begin
        if (reset)
            taps <= '0;
        else if (shift)
            taps <= {taps[NTAP-2:0], din_in};
    end

    for (genvar n = 0; n < NBANK; n++) begin : g_bank
        for (genvar j = 0; j < ADDR_W; j++) begin : g_tap
            assign slice[n][j] = taps[n*ADDR_W+j][bit_sel];
        end
    end
endmodule

// File: rtl/da_slice_feeder.sv
// Feeds MSB-first bit-slice addresses to the DA core for each accepted sample and captures the result.
module da_slice_feeder
    import da_pkg::*;
#(
    parameter int SW            = da_pkg::SW,
    parameter int NTAP          = da_pkg::NTAP,
    parameter int OFFSET_BINARY = 1,
    parameter int ACC_SETTLE    = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SW-1:0]     s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              cload_busy,
    output logic [ADDR_W-1:0] a7,
    output logic [ADDR_W-1:0] a6,
    output logic [ADDR_W-1:0] a5,
    output logic [ADDR_W-1:0] a4,
    output logic [ADDR_W-1:0] a3,
    output logic [ADDR_W-1:0] a2,
    output logic [ADDR_W-1:0] a1,
    output logic [ADDR_W-1:0] a0,
    output logic              da_start,
    input  logic              da_done,
    output logic              da_acc_clr,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  y_data,
    output logic              y_valid,
    output logic              busy,
    output logic              err
);
    localparam int BW   = $clog2(SW);
    localparam int CMAX = (TIMEOUT > ACC_SETTLE) ? TIMEOUT : ACC_SETTLE;
    localparam int CW   = $clog2(CMAX + 1);

    state_t                         state, state_nxt;
    logic [BW-1:0]                  bit_idx, bit_nxt;
    logic [CW-1:0]                  cnt;
    logic [NBANK-1:0][ADDR_W-1:0]   addr, slice;
    logic                           accept, load_addr, to_hit, capture;

    assign s_ready    = (state == IDLE) && !cload_busy;
    assign accept     = s_valid && s_ready;
    assign da_start   = (state == ISSUE);
    assign da_acc_clr = (state == CLEAR);
    assign busy       = (state != IDLE);

    assign {a7, a6, a5, a4, a3, a2, a1, a0} = addr;

    // Slice select follows the next bit index so addresses are valid during ISSUE.
    da_delay_line #(
        .SW(SW),
        .NTAP(NTAP),
        .OFFSET_BINARY(OFFSET_BINARY)
    ) u_line (
        .clk(clk),
        .reset(reset),
        .shift(accept),
        .din(s_data),
        .bit_sel(bit_nxt),
        .slice(slice)
    );

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_idx;
        load_addr = 1'b0;
        to_hit    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                bit_nxt   = BW'(SW - 1);
                load_addr = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // A done arriving on the timeout cycle wins.
                if (da_done) begin
                    if (bit_idx != '0) begin
                        bit_nxt   = bit_idx - 1'b1;
                        load_addr = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = SETTLE;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    to_hit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SETTLE: begin
                // The y_valid cycle stays in SETTLE so the next accept lands after it.
                if (y_valid)
                    state_nxt = IDLE;
                else if (cnt == CW'(ACC_SETTLE - 1))
                    capture = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_idx <= '0;
            cnt     <= '0;
            addr    <= '0;
            y_data  <= '0;
            y_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_nxt;
            if ((state == WAIT || state == SETTLE) && state_nxt == state)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (load_addr)
                addr <= slice;
            y_valid <= capture;
            if (capture)
                y_data <= acc_in;
            if (to_hit)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_da_slice_feeder.sv
// Bench for da_slice_feeder: one plain-binary instance and one offset-binary instance with a short timeout.
module tb_da_slice_feeder;
    localparam int ACC_SETTLE = 1;
    localparam int TO2        = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] s_data1, s_data2;
    logic        s_valid1, s_valid2, cload1, cload2;
    logic [38:0] acc1, acc2;
    logic        s_ready1, s_ready2;
    logic [7:0][7:0] ad1, ad2;
    logic        start1, start2, clr1, clr2, yv1, yv2, busy1, busy2, err1, err2;
    logic [38:0] yd1, yd2;
    logic        da_done1 = 1'b0, da_done2 = 1'b0;
    int          dly1, dly2, pend1, pend2;

    da_slice_feeder #(.OFFSET_BINARY(0)) dut (
        .clk(clk), .reset(reset), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .cload_busy(cload1), .a7(ad1[7]), .a6(ad1[6]), .a5(ad1[5]), .a4(ad1[4]),
        .a3(ad1[3]), .a2(ad1[2]), .a1(ad1[1]), .a0(ad1[0]), .da_start(start1),
        .da_done(da_done1), .da_acc_clr(clr1), .acc_in(acc1), .y_data(yd1),
        .y_valid(yv1), .busy(busy1), .err(err1)
    );

    da_slice_feeder #(.OFFSET_BINARY(1), .TIMEOUT(TO2)) dut_ob (
        .clk(clk), .reset(reset), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
        .cload_busy(cload2), .a7(ad2[7]), .a6(ad2[6]), .a5(ad2[5]), .a4(ad2[4]),
        .a3(ad2[3]), .a2(ad2[2]), .a1(ad2[1]), .a0(ad2[0]), .da_start(start2),
        .da_done(da_done2), .da_acc_clr(clr2), .acc_in(acc2), .y_data(yd2),
        .y_valid(yv2), .busy(busy2), .err(err2)
    );

    // DA core models: done pulses dly cycles after the start cycle; dly == 0 never answers.
    always @(negedge clk) begin
        da_done1 = 1'b0;
        if (reset) pend1 = 0;
        else if (start1) pend1 = dly1;
        else if (pend1 > 0) begin
            pend1--;
            if (pend1 == 0) da_done1 = 1'b1;
        end
    end
    always @(negedge clk) begin
        da_done2 = 1'b0;
        if (reset) pend2 = 0;
        else if (start2) pend2 = dly2;
        else if (pend2 > 0) begin
            pend2--;
            if (pend2 == 0) da_done2 = 1'b1;
        end
    end

    bit sel, stable_chk;
    logic [63:0] addr_m;
    logic        start_m, clr_m, yv_m, busy_m, ready_m, err_m;
    logic [38:0] yd_m;
    assign addr_m  = sel ? ad2 : ad1;
    assign start_m = sel ? start2 : start1;
    assign clr_m   = sel ? clr2 : clr1;
    assign yv_m    = sel ? yv2 : yv1;
    assign yd_m    = sel ? yd2 : yd1;
    assign busy_m  = sel ? busy2 : busy1;
    assign ready_m = sel ? s_ready2 : s_ready1;
    assign err_m   = sel ? err2 : err1;

    int          checks = 0, errors = 0;
    logic [15:0] mtap [2][64];
    logic [63:0] aq [$];
    logic [38:0] yq [$];
    logic [63:0] obs [16];

    typedef struct {
        logic [15:0] din;
        logic [38:0] acc;
        logic [7:0]  s15, s1, s0;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clear_model();
        aq.delete();
        yq.delete();
        for (int s = 0; s < 2; s++)
            for (int t = 0; t < 64; t++) mtap[s][t] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // One sample through the selected instance; entered and left on a falling edge.
    task automatic txn(input logic [15:0] din, input logic [38:0] acc, input int dly,
                       input int abort_at, input bit exp_to);
        int k, nclr, nstart, t_start, lat;
        logic [63:0] w, got, snap;
        bit fin;
        k = 0;
        while (!ready_m && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ready", 64'(ready_m), 64'd1);
        if (sel) begin s_data2 = din; s_valid2 = 1'b1; acc2 = acc; dly2 = dly; end
        else     begin s_data1 = din; s_valid1 = 1'b1; acc1 = acc; dly1 = dly; end
        for (int t = 63; t > 0; t--) mtap[sel][t] = mtap[sel][t-1];
        mtap[sel][0] = sel ? (din ^ 16'h8000) : din;
        for (int b = 15; b >= 0; b--) begin
            for (int t = 0; t < 64; t++) w[t] = mtap[sel][t][b];
            aq.push_back(w);
        end
        if (!exp_to) yq.push_back(acc);
        nclr = 0; nstart = 0; t_start = 0; lat = 0; fin = 1'b0; snap = '0;
        @(negedge clk);
        s_valid1 = 1'b0;
        s_valid2 = 1'b0;
        for (k = 1; k < 4000 && !fin; k++) begin
            if (clr_m) nclr++;
            if (start_m) begin
                got = addr_m;
                if (aq.size() == 0) chk("extra_start", 64'(nstart), 64'd16);
                else chk("slice_addr", got, aq.pop_front());
                if (nstart < 16) obs[15-nstart] = got;
                snap = got;
                nstart++;
                t_start = k;
            end else if (stable_chk && nstart > 0 && busy_m) begin
                chk("addr_hold", addr_m, snap);
            end
            if (yv_m) begin
                if (yq.size() == 0) chk("unexp_yvalid", 64'(yv_m), 64'd0);
                else chk("y_data", 64'(yd_m), 64'(yq.pop_front()));
                lat = k;
                fin = 1'b1;
            end else if (exp_to && err_m) begin
                lat = k - t_start;
                fin = 1'b1;
            end else if (abort_at != 0 && nstart == abort_at) begin
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        chk("txn_finished", 64'(fin), 64'd1);
        if (abort_at == 0) begin
            if (exp_to) begin
                chk("to_cycles", 64'(lat), 64'(TO2 + 1));
                chk("to_starts", 64'(nstart), 64'd1);
                chk("to_idle", 64'(busy_m), 64'd0);
                chk("to_ready", 64'(ready_m), 64'd1);
                aq.delete();
            end else begin
                chk("clr_pulses", 64'(nclr), 64'd1);
                chk("start_pulses", 64'(nstart), 64'd16);
                chk("latency", 64'(lat), 64'(1 + 16*(1 + dly) + ACC_SETTLE + 1));
            end
        end
    endtask

    initial begin
        int ycount;
        tbl[0] = '{16'h8001, 39'h12_3456_789A, 8'h01, 8'h00, 8'h01};
        tbl[1] = '{16'h0003, 39'h7F_0000_0001, 8'h02, 8'h01, 8'h03};
        tbl[2] = '{16'hA5C3, 39'h00_DEAD_BEEF, 8'h05, 8'h03, 8'h07};
        tbl[3] = '{16'h7FFE, 39'h40_0000_0000, 8'h0A, 8'h07, 8'h0E};

        reset = 1'b1; sel = 1'b0; stable_chk = 1'b0;
        s_data1 = '0; s_data2 = '0; s_valid1 = 1'b0; s_valid2 = 1'b0;
        cload1 = 1'b0; cload2 = 1'b0; acc1 = '0; acc2 = '0; dly1 = 2; dly2 = 2;
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_addr", ad1, 64'd0);
        chk("rst_start", 64'(start1), 64'd0);
        chk("rst_clr", 64'(clr1), 64'd0);
        chk("rst_yvalid", 64'(yv1), 64'd0);
        chk("rst_ydata", 64'(yd1), 64'd0);
        chk("rst_err", 64'(err1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_ready", 64'(s_ready1), 64'd1);

        cload1 = 1'b1;
        @(negedge clk);
        chk("cload_ready", 64'(s_ready1), 64'd0);
        s_data1 = 16'h1234; s_valid1 = 1'b1;
        repeat (4) @(negedge clk);
        chk("cload_blocks", 64'(busy1), 64'd0);
        s_valid1 = 1'b0; cload1 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            txn(tbl[i].din, tbl[i].acc, 2, 0, 1'b0);
            chk($sformatf("vec%0d_a0_s15", i), 64'(obs[15][7:0]), 64'(tbl[i].s15));
            chk($sformatf("vec%0d_a0_s1", i), 64'(obs[1][7:0]), 64'(tbl[i].s1));
            chk($sformatf("vec%0d_a0_s0", i), 64'(obs[0][7:0]), 64'(tbl[i].s0));
            if (i == 0)
                for (int b = 0; b < 16; b++) chk("vec0_upper", obs[b] >> 8, 64'd0);
        end

        // Reset during the wait of slice 7.
        txn(16'h5A5A, 39'h11, 2, 9, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy1), 64'd0);
        chk("midrst_addr", ad1, 64'd0);
        chk("midrst_start", 64'(start1), 64'd0);
        reset = 1'b0;
        clear_model();
        ycount = 0;
        repeat (60) begin
            @(negedge clk);
            if (yv1) ycount++;
        end
        chk("midrst_no_yvalid", 64'(ycount), 64'd0);
        txn(16'h0000, 39'h22, 2, 0, 1'b0);

        // Single full-scale sample walks to tap 63 and then falls off.
        do_reset();
        for (int i = 0; i < 65; i++) begin
            txn((i == 0) ? 16'hFFFF : 16'h0000, 39'(i), 2, 0, 1'b0);
            if (i == 63)
                for (int b = 0; b < 16; b++) chk("tap63_a7", obs[b], 64'h8000_0000_0000_0000);
            if (i == 64)
                for (int b = 0; b < 16; b++) chk("tap_gone", obs[b], 64'd0);
        end

        stable_chk = 1'b1;
        txn(16'h1357, 39'h55_5555_5555, 20, 0, 1'b0);
        stable_chk = 1'b0;

        // Offset-binary instance; done lands exactly on the timeout cycle.
        sel = 1'b1;
        txn(16'h0000, 39'h33, TO2, 0, 1'b0);
        chk("ob_s15", obs[15], 64'h01);
        for (int b = 0; b < 15; b++) chk("ob_low", obs[b], 64'd0);
        chk("done_at_timeout", 64'(err2), 64'd0);

        txn(16'h2222, 39'h0, 0, 0, 1'b1);
        chk("to_err", 64'(err2), 64'd1);
        txn(16'h0001, 39'h44, 2, 0, 1'b0);
        chk("err_sticky", 64'(err2), 64'd1);
        do_reset();
        chk("err_cleared", 64'(err2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
